// File: rtl/hack_ps2_keyboard.sv
// PS/2 scan-code-set-2 receiver and Hack key-code translator.
// Drives the keyboard register read back by the CPU with the code of the held key.
module hack_ps2_keyboard #(
  parameter int WIDTH      = 16,
  parameter int FREQ       = 25,
  parameter int TIMEOUT_US = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  output logic [WIDTH-1:0] key_code,
  output logic             key_event,
  output logic             frame_err
);

  localparam int TO_CYCLES = FREQ * TIMEOUT_US;
  localparam int TO_W      = $clog2(TO_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_e;

  rx_state_e        state_q, state_d;
  logic [1:0]       clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
  logic [2:0]       clk_hist_q, clk_hist_d;
  logic             clk_filt_q, clk_filt_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             parity_q, parity_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             ext_q, ext_d, brk_q, brk_d;
  logic [WIDTH-1:0] key_code_q, key_code_d;
  logic             key_event_q, key_event_d;
  logic             fall_edge, rx_bit, timeout;
  logic [7:0]       mapped;

  function automatic logic [7:0] map_code(input logic [7:0] sc, input logic ext);
    logic [7:0] v;
    v = 8'd0;
    if (ext) begin
      case (sc)
        8'h6B: v = 8'd130; 8'h75: v = 8'd131; 8'h74: v = 8'd132; 8'h72: v = 8'd133;
        8'h6C: v = 8'd134; 8'h69: v = 8'd135; 8'h7D: v = 8'd136; 8'h7A: v = 8'd137;
        8'h70: v = 8'd138; 8'h71: v = 8'd139;
        default: v = 8'd0;
      endcase
    end else begin
      case (sc)
        8'h1C: v = 8'd65; 8'h32: v = 8'd66; 8'h21: v = 8'd67; 8'h23: v = 8'd68;
        8'h24: v = 8'd69; 8'h2B: v = 8'd70; 8'h34: v = 8'd71; 8'h33: v = 8'd72;
        8'h43: v = 8'd73; 8'h3B: v = 8'd74; 8'h42: v = 8'd75; 8'h4B: v = 8'd76;
        8'h3A: v = 8'd77; 8'h31: v = 8'd78; 8'h44: v = 8'd79; 8'h4D: v = 8'd80;
        8'h15: v = 8'd81; 8'h2D: v = 8'd82; 8'h1B: v = 8'd83; 8'h2C: v = 8'd84;
        8'h3C: v = 8'd85; 8'h2A: v = 8'd86; 8'h1D: v = 8'd87; 8'h22: v = 8'd88;
        8'h35: v = 8'd89; 8'h1A: v = 8'd90;
        8'h45: v = 8'd48; 8'h16: v = 8'd49; 8'h1E: v = 8'd50; 8'h26: v = 8'd51;
        8'h25: v = 8'd52; 8'h2E: v = 8'd53; 8'h36: v = 8'd54; 8'h3D: v = 8'd55;
        8'h3E: v = 8'd56; 8'h46: v = 8'd57;
        8'h29: v = 8'd32; 8'h5A: v = 8'd128; 8'h66: v = 8'd129; 8'h76: v = 8'd140;
        8'h05: v = 8'd141; 8'h06: v = 8'd142; 8'h04: v = 8'd143; 8'h0C: v = 8'd144;
        8'h03: v = 8'd145; 8'h0B: v = 8'd146; 8'h83: v = 8'd147; 8'h0A: v = 8'd148;
        8'h01: v = 8'd149; 8'h09: v = 8'd150; 8'h78: v = 8'd151; 8'h07: v = 8'd152;
        default: v = 8'd0;
      endcase
    end
    return v;
  endfunction

  // Front end: synchronizers plus a 3-sample filter on the PS/2 clock.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    clk_sync_d = {clk_sync_q[0], ps2_clk};
    dat_sync_d = {dat_sync_q[0], ps2_data};
    clk_hist_d = {clk_hist_q[1:0], clk_sync_q[1]};
    clk_filt_d = clk_filt_q;
    if (clk_hist_q == 3'b111) clk_filt_d = 1'b1;
    else if (clk_hist_q == 3'b000) clk_filt_d = 1'b0;
    fall_edge = clk_filt_q && (clk_hist_q == 3'b000);
    rx_bit    = dat_sync_q[1];
  end

  // Receiver next-state.
  always_comb begin
    timeout = (state_q != IDLE) && !fall_edge && (to_cnt_q == TO_W'(TO_CYCLES - 1));
    state_d = state_q;
    case (state_q)
      IDLE:    if (fall_edge && !rx_bit) state_d = DATA;
      DATA:    if (fall_edge && bit_cnt_q == 3'd7) state_d = PARITY;
      PARITY:  if (fall_edge) state_d = STOP;
      STOP:    if (fall_edge) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (timeout) state_d = IDLE;
  end

  // Receiver datapath and outputs.
  always_comb begin
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    parity_d     = parity_q;
    to_cnt_d     = (state_q == IDLE || fall_edge) ? '0 : to_cnt_q + 1'b1;
    byte_valid_d = 1'b0;
    frame_err_d  = timeout;
    if (fall_edge) begin
      case (state_q)
        IDLE: begin
          bit_cnt_d = 3'd0;
          if (rx_bit) frame_err_d = 1'b1;
        end
        DATA: begin
          shift_d   = {rx_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
        PARITY: parity_d = rx_bit;
        STOP: begin
          // Odd parity over data+parity and a high stop bit.
          if (rx_bit && ^{shift_q, parity_q}) byte_valid_d = 1'b1;
          else frame_err_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Decoder: prefix flags and the held-key register.
  always_comb begin
    ext_d       = ext_q;
    brk_d       = brk_q;
    key_code_d  = key_code_q;
    key_event_d = 1'b0;
    mapped      = map_code(shift_q, ext_q);
    if (byte_valid_q) begin
      if (shift_q == 8'hE0) ext_d = 1'b1;
      else if (shift_q == 8'hF0) brk_d = 1'b1;
      else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (mapped != 8'd0) begin
          if (!brk_q) begin
            if (key_code_q != WIDTH'(mapped)) begin
              key_code_d  = WIDTH'(mapped);
              key_event_d = 1'b1;
            end
          end else if (key_code_q == WIDTH'(mapped)) begin
            key_code_d  = '0;
            key_event_d = 1'b1;
          end
        end
      end
    end
  end

  // NOTE: state uses non-blocking assignments; reset is synchronous, and the
  // synchronizers reset to the idle-high bus level so reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q   <= 2'b11;
      dat_sync_q   <= 2'b11;
      clk_hist_q   <= 3'b111;
      clk_filt_q   <= 1'b1;
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      parity_q     <= 1'b0;
      to_cnt_q     <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      key_code_q   <= '0;
      key_event_q  <= 1'b0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      dat_sync_q   <= dat_sync_d;
      clk_hist_q   <= clk_hist_d;
      clk_filt_q   <= clk_filt_d;
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      parity_q     <= parity_d;
      to_cnt_q     <= to_cnt_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      key_code_q   <= key_code_d;
      key_event_q  <= key_event_d;
    end
  end

  assign key_code  = key_code_q;
  assign key_event = key_event_q;
  assign frame_err = frame_err_q;

endmodule
